lsu_axi: RTL and testbench

- Memory-access stage between the execute unit and write-back.
- Accepts one instruction at a time from the execute unit over a valid/ready handshake.
- Loads issue a single-beat AXI4 read. Stores issue a single-beat AXI4 write with AW and W driven together. Non-memory ops pass straight through.
- Presents a registered result to write-back over a second valid/ready handshake.

---
 rtl/lsu_axi.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_axi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi.sv
// Memory-access stage: single-beat AXI4 loads/stores, pass-through for ALU ops.
// Optional YSYX_23060251_LSU_FAULT_EN adds fault_o for non-OKAY R/B responses.
module lsu_axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              e_valid_i,
  output logic              M_ready_o,
  input  logic              renMem_i,
  input  logic              wenMem_i,
  input  logic              is_load_signed_i,
  input  logic [1:0]        mask_i,
  input  logic [DATA_W-1:0] res_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wenReg_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              mst_ar_valid_o,
  output logic [ADDR_W-1:0] mst_ar_addr_o,
  output logic [2:0]        mst_ar_size_o,
  input  logic              mst_ar_ready_i,
  input  logic              mst_r_valid_i,
  input  logic [DATA_W-1:0] mst_r_data_i,
  input  logic [1:0]        mst_r_resp_i,
  output logic              mst_r_ready_o,
  output logic              mst_aw_valid_o,
  output logic [ADDR_W-1:0] mst_aw_addr_o,
  output logic [2:0]        mst_aw_size_o,
  input  logic              mst_aw_ready_i,
  output logic              mst_w_valid_o,
  output logic [DATA_W-1:0] mst_w_data_o,
  output logic [3:0]        mst_w_strb_o,
  output logic              mst_w_last_o,
  input  logic              mst_w_ready_i,
  input  logic              mst_b_valid_i,
  input  logic [1:0]        mst_b_resp_i,
  output logic              mst_b_ready_o,
  output logic              W_valid_o,
  input  logic              w_ready_i,
  output logic [DATA_W-1:0] w_data_o,
  output logic [RD_W-1:0]   w_rd_o,
  output logic              w_wenReg_o,
`ifdef YSYX_23060251_LSU_FAULT_EN
  output logic              fault_o,
`endif
  output logic              w_renMem_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, OUT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          mask_q;
  logic                signed_q;
  logic                aw_done_q, w_done_q;
  logic [4:0]          lane_sh;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   load_data;
  logic [2:0]          access_size;
  logic [3:0]          strb_base;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    M_ready_o      = 1'b0;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    W_valid_o      = 1'b0;
    case (state_q)
      IDLE: begin
        M_ready_o = 1'b1;
        if (e_valid_i) begin
          if (renMem_i)      state_d = RD_ADDR;
          else if (wenMem_i) state_d = WR_REQ;
          else               state_d = OUT;
        end
      end
      RD_ADDR: begin
        mst_ar_valid_o = 1'b1;
        if (mst_ar_ready_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        mst_r_ready_o = 1'b1;
        if (mst_r_valid_i) state_d = OUT;
      end
      WR_REQ: begin
        mst_aw_valid_o = !aw_done_q;
        mst_w_valid_o  = !w_done_q;
        if ((aw_done_q || mst_aw_ready_i) && (w_done_q || mst_w_ready_i)) state_d = WR_RESP;
      end
      WR_RESP: begin
        mst_b_ready_o = 1'b1;
        if (mst_b_valid_i) state_d = OUT;
      end
      OUT: begin
        W_valid_o = 1'b1;
        if (w_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lane_sh = {addr_q[1:0], 3'b000};
  assign r_shift = mst_r_data_i >> lane_sh;

  always_comb begin
    load_data = r_shift;
    case (mask_q)
      2'b00:   load_data = {{(DATA_W-8){signed_q & r_shift[7]}}, r_shift[7:0]};
      2'b01:   load_data = {{(DATA_W-16){signed_q & r_shift[15]}}, r_shift[15:0]};
      default: load_data = r_shift;
    endcase
  end

  always_comb begin
    access_size = 3'd2;
    strb_base   = 4'b1111;
    case (mask_q)
      2'b00:   begin access_size = 3'd0; strb_base = 4'b0001; end
      2'b01:   begin access_size = 3'd1; strb_base = 4'b0011; end
      default: begin access_size = 3'd2; strb_base = 4'b1111; end
    endcase
  end

  assign mst_ar_addr_o = addr_q;
  assign mst_ar_size_o = access_size;
  assign mst_aw_addr_o = addr_q;
  assign mst_aw_size_o = access_size;
  assign mst_w_data_o  = wdata_q << lane_sh;
  // Lanes shifted past bit 3 fall off the 4-bit strobe.
  assign mst_w_strb_o  = (state_q == WR_REQ) ? (strb_base << addr_q[1:0]) : '0;
  assign mst_w_last_o  = 1'b1;

`ifdef YSYX_23060251_LSU_FAULT_EN
  logic fault_q;
  assign fault_o = fault_q;
`else
  logic unused_resp;
  assign unused_resp = ^{mst_r_resp_i, mst_b_resp_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      signed_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      w_data_o   <= '0;
      w_rd_o     <= '0;
      w_wenReg_o <= 1'b0;
      w_renMem_o <= 1'b0;
`ifdef YSYX_23060251_LSU_FAULT_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && e_valid_i) begin
        addr_q     <= res_i[ADDR_W-1:0];
        wdata_q    <= wdata_i;
        mask_q     <= mask_i;
        signed_q   <= is_load_signed_i;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
        w_data_o   <= res_i;
        w_rd_o     <= rd_i;
        w_wenReg_o <= wenReg_i & ~wenMem_i;
        w_renMem_o <= renMem_i;
`ifdef YSYX_23060251_LSU_FAULT_EN
        fault_q    <= 1'b0;
`endif
      end
      if (mst_aw_valid_o && mst_aw_ready_i) aw_done_q <= 1'b1;
      if (mst_w_valid_o && mst_w_ready_i)   w_done_q  <= 1'b1;
      if (state_q == RD_DATA && mst_r_valid_i) begin
        w_data_o <= load_data;
`ifdef YSYX_23060251_LSU_FAULT_EN
        if (mst_r_resp_i != 2'b00) begin
          fault_q    <= 1'b1;
          w_wenReg_o <= 1'b0;
        end
`endif
      end
`ifdef YSYX_23060251_LSU_FAULT_EN
      if (state_q == WR_RESP && mst_b_valid_i && mst_b_resp_i != 2'b00) fault_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_axi.sv
// Self-checking bench for lsu_axi: directed cases plus randomized ops against a reference model.
module tb_lsu_axi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        e_valid_i, M_ready_o, renMem_i, wenMem_i, is_load_signed_i;
  logic [1:0]  mask_i;
  logic [31:0] res_i, wdata_i;
  logic        wenReg_i;
  logic [4:0]  rd_i;
  logic        mst_ar_valid_o, mst_ar_ready_i;
  logic [31:0] mst_ar_addr_o;
  logic [2:0]  mst_ar_size_o;
  logic        mst_r_valid_i, mst_r_ready_o;
  logic [31:0] mst_r_data_i;
  logic [1:0]  mst_r_resp_i;
  logic        mst_aw_valid_o, mst_aw_ready_i;
  logic [31:0] mst_aw_addr_o;
  logic [2:0]  mst_aw_size_o;
  logic        mst_w_valid_o, mst_w_last_o, mst_w_ready_i;
  logic [31:0] mst_w_data_o;
  logic [3:0]  mst_w_strb_o;
  logic        mst_b_valid_i, mst_b_ready_o;
  logic [1:0]  mst_b_resp_i;
  logic        W_valid_o, w_ready_i;
  logic [31:0] w_data_o;
  logic [4:0]  w_rd_o;
  logic        w_wenReg_o, w_renMem_o;
`ifdef YSYX_23060251_LSU_FAULT_EN
  logic        fault_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  lsu_axi #(.ADDR_W(32), .DATA_W(32), .RD_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .e_valid_i(e_valid_i), .M_ready_o(M_ready_o),
    .renMem_i(renMem_i), .wenMem_i(wenMem_i), .is_load_signed_i(is_load_signed_i),
    .mask_i(mask_i), .res_i(res_i), .wdata_i(wdata_i), .wenReg_i(wenReg_i), .rd_i(rd_i),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_addr_o(mst_ar_addr_o),
    .mst_ar_size_o(mst_ar_size_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_data_i(mst_r_data_i),
    .mst_r_resp_i(mst_r_resp_i), .mst_r_ready_o(mst_r_ready_o),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_addr_o(mst_aw_addr_o),
    .mst_aw_size_o(mst_aw_size_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_data_o(mst_w_data_o),
    .mst_w_strb_o(mst_w_strb_o), .mst_w_last_o(mst_w_last_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_resp_i(mst_b_resp_i), .mst_b_ready_o(mst_b_ready_o),
    .W_valid_o(W_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_rd_o(w_rd_o), .w_wenReg_o(w_wenReg_o),
`ifdef YSYX_23060251_LSU_FAULT_EN
    .fault_o(fault_o),
`endif
    .w_renMem_o(w_renMem_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte lanes counted from the low address bits, sizes 1/2/4 bytes.
  function automatic int nbytes(input logic [1:0] mask);
    return (mask == 2'd0) ? 1 : (mask == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [31:0] rdata,
                                           input logic [1:0] mask, input logic sgn);
    logic [63:0] v;
    int n;
    n = nbytes(mask);
    v = {32'd0, rdata} >> (8 * int'(addr[1:0]));
    v = v % (64'd1 << (8 * n));
    if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + 64'hFFFF_FFFF_0000_0000 - (64'd1 << (8 * n)) + 64'h1_0000_0000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] addr, input logic [31:0] wd);
    logic [63:0] v;
    v = {32'd0, wd} * (64'd1 << (8 * int'(addr[1:0])));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] addr, input logic [1:0] mask);
    int s;
    s = ((1 << nbytes(mask)) - 1) << int'(addr[1:0]);
    return 4'(s % 16);
  endfunction

  task automatic idle_slave();
    mst_ar_ready_i = 0; mst_r_valid_i = 0; mst_r_data_i = $urandom; mst_r_resp_i = 0;
    mst_aw_ready_i = 0; mst_w_ready_i = 0; mst_b_valid_i = 0; mst_b_resp_i = 0; w_ready_i = 0;
  endtask

  task automatic run_op(input logic ld, input logic st, input logic sgn, input logic [1:0] mask,
                        input logic [31:0] res, input logic [31:0] wd, input logic wen,
                        input logic [4:0] rd, input logic [31:0] rdata, input logic [1:0] resp,
                        input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                        input int b_dly, input int b_extra, input int out_dly);
    logic [31:0] exp_data;
    logic        exp_wen, exp_fault;
    int exp_lat, lat, cyc;
    int ar_n, r_n, aw_n, w_n, b_n, ar_wait, r_wait, aw_wait, w_wait, b_wait, out_wait, extra_left;
    logic done, hs_ar, hs_r, hs_aw, hs_w, hs_b;
    exp_data  = ld ? ref_load(res, rdata, mask, sgn) : res;
    exp_fault = (ld || st) && (resp != 2'b00);
    exp_wen   = st ? 1'b0 : wen;
`ifdef YSYX_23060251_LSU_FAULT_EN
    if (ld && exp_fault) exp_wen = 1'b0;
`endif
    if (ld)      exp_lat = 3 + ar_dly + r_dly;
    else if (st) exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    else         exp_lat = 1;
    {ar_n, r_n, aw_n, w_n, b_n} = '0;
    {ar_wait, r_wait, aw_wait, w_wait, b_wait, out_wait} = '0;
    extra_left = b_extra; lat = -1; done = 0; cyc = 0;

    e_valid_i = 1; renMem_i = ld; wenMem_i = st; is_load_signed_i = sgn; mask_i = mask;
    res_i = res; wdata_i = wd; wenReg_i = wen; rd_i = rd;
    check("m_ready_idle", {31'd0, M_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    e_valid_i = 0; res_i = $urandom; wdata_i = $urandom; rd_i = 5'($urandom);
    mask_i = 2'($urandom); renMem_i = 0; wenMem_i = 0; wenReg_i = 1'($urandom);

    while (!done && cyc < 200) begin
      cyc++;
      if (mst_ar_valid_o) begin
        check("ar_addr", mst_ar_addr_o, res);
        check("ar_size", {29'd0, mst_ar_size_o}, (mask == 0) ? 0 : (mask == 1) ? 1 : 2);
      end
      if (mst_aw_valid_o) begin
        check("aw_addr", mst_aw_addr_o, res);
        check("aw_size", {29'd0, mst_aw_size_o}, (mask == 0) ? 0 : (mask == 1) ? 1 : 2);
      end
      if (mst_w_valid_o) begin
        check("w_data", mst_w_data_o, ref_wdata(res, wd));
        check("w_strb", {28'd0, mst_w_strb_o}, {28'd0, ref_strb(res, mask)});
        check("w_last", {31'd0, mst_w_last_o}, 32'd1);
      end
      if (W_valid_o) begin
        if (lat < 0) begin
          lat = cyc;
          check("latency", lat, exp_lat);
        end
        check("wb_data", w_data_o, exp_data);
        check("wb_rd", {27'd0, w_rd_o}, {27'd0, rd});
        check("wb_wen", {31'd0, w_wenReg_o}, {31'd0, exp_wen});
        check("wb_ren", {31'd0, w_renMem_o}, {31'd0, ld});
        check("m_ready_busy", {31'd0, M_ready_o}, 32'd0);
`ifdef YSYX_23060251_LSU_FAULT_EN
        check("fault", {31'd0, fault_o}, {31'd0, exp_fault});
`endif
      end

      mst_ar_ready_i = mst_ar_valid_o && ar_wait >= ar_dly;
      mst_r_valid_i  = ar_n > 0 && r_n == 0 && r_wait >= r_dly;
      mst_r_data_i   = mst_r_valid_i ? rdata : $urandom;
      mst_r_resp_i   = mst_r_valid_i ? resp : 2'($urandom);
      mst_aw_ready_i = mst_aw_valid_o && aw_wait >= aw_dly;
      mst_w_ready_i  = mst_w_valid_o && w_wait >= w_dly;
      mst_b_valid_i  = aw_n > 0 && w_n > 0 &&
                       ((b_n == 0 && b_wait >= b_dly) || (b_n > 0 && extra_left > 0));
      mst_b_resp_i   = mst_b_valid_i ? resp : 2'($urandom);
      w_ready_i      = W_valid_o && out_wait >= out_dly;

      hs_ar = mst_ar_valid_o && mst_ar_ready_i;
      hs_r  = mst_r_valid_i && mst_r_ready_o;
      hs_aw = mst_aw_valid_o && mst_aw_ready_i;
      hs_w  = mst_w_valid_o && mst_w_ready_i;
      hs_b  = mst_b_valid_i && mst_b_ready_o;
      if (mst_ar_valid_o) ar_wait++;
      if (ar_n > 0 && r_n == 0) r_wait++;
      if (mst_aw_valid_o) aw_wait++;
      if (mst_w_valid_o) w_wait++;
      if (aw_n > 0 && w_n > 0 && b_n == 0) b_wait++;
      if (b_n > 0 && mst_b_valid_i) extra_left--;
      if (W_valid_o) out_wait++;
      if (W_valid_o && w_ready_i) done = 1;
      ar_n += int'(hs_ar); r_n += int'(hs_r); aw_n += int'(hs_aw); w_n += int'(hs_w); b_n += int'(hs_b);
      @(posedge clk_i); #1;
    end
    idle_slave();
    check("completed", {31'd0, done}, 32'd1);
    check("ar_count", ar_n, ld ? 1 : 0);
    check("r_count", r_n, ld ? 1 : 0);
    check("aw_count", aw_n, st ? 1 : 0);
    check("w_count", w_n, st ? 1 : 0);
    check("b_count", b_n, st ? 1 : 0);
  endtask

  initial begin
    e_valid_i = 0; renMem_i = 0; wenMem_i = 0; is_load_signed_i = 0; mask_i = 0;
    res_i = 0; wdata_i = 0; wenReg_i = 0; rd_i = 0;
    idle_slave();
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_m_ready", {31'd0, M_ready_o}, 32'd1);
    check("rst_valids", {26'd0, mst_ar_valid_o, mst_r_ready_o, mst_aw_valid_o,
                         mst_w_valid_o, mst_b_ready_o, W_valid_o}, 32'd0);
    check("rst_w_data", w_data_o, 32'd0);
    check("rst_w_misc", {25'd0, w_rd_o, w_wenReg_o, w_renMem_o}, 32'd0);
    check("rst_ar_addr", mst_ar_addr_o, 32'd0);
    check("rst_strb", {28'd0, mst_w_strb_o}, 32'd0);
    rst_i = 0;

    // ALU pass-through
    run_op(0, 0, 0, 2'd2, 32'h1234, 32'h0, 1, 5'd5, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    // Loads: signed/unsigned byte at lane 3, half at lane 2
    run_op(1, 0, 1, 2'd0, 32'h8000_0003, 32'h0, 1, 5'd7, 32'h8011_2233, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    run_op(1, 0, 0, 2'd0, 32'h8000_0003, 32'h0, 1, 5'd8, 32'h8011_2233, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    run_op(1, 0, 0, 2'd1, 32'h8000_0002, 32'h0, 1, 5'd9, 32'hBEEF_0000, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    // Store byte: AW three cycles ahead of W, B held one extra cycle
    run_op(0, 1, 0, 2'd0, 32'h8000_0001, 32'h0000_00AB, 1, 5'd3, 32'h0, 2'd0, 0, 0, 0, 3, 0, 1, 2);
    // Write-back back-pressure, then immediate next op
    run_op(0, 0, 0, 2'd2, 32'hCAFE_F00D, 32'h0, 1, 5'd31, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0, 4);
    run_op(0, 1, 0, 2'd2, 32'h0000_1000, 32'h1357_9BDF, 0, 5'd1, 32'h0, 2'd0, 0, 0, 2, 0, 1, 0, 0);

    // Reset while waiting for read data
    e_valid_i = 1; renMem_i = 1; wenMem_i = 0; mask_i = 2'd2; res_i = 32'h100; rd_i = 5'd4; wenReg_i = 1;
    @(posedge clk_i); #1;
    e_valid_i = 0; renMem_i = 0;
    check("rstmid_ar_valid", {31'd0, mst_ar_valid_o}, 32'd1);
    mst_ar_ready_i = 1;
    @(posedge clk_i); #1;
    mst_ar_ready_i = 0;
    check("rstmid_r_ready_pre", {31'd0, mst_r_ready_o}, 32'd1);
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    check("rstmid_m_ready", {31'd0, M_ready_o}, 32'd1);
    check("rstmid_r_ready", {31'd0, mst_r_ready_o}, 32'd0);
    check("rstmid_w_valid", {31'd0, W_valid_o}, 32'd0);

`ifdef YSYX_23060251_LSU_FAULT_EN
    run_op(1, 0, 0, 2'd2, 32'h200, 32'h0, 1, 5'd6, 32'h1111_2222, 2'd2, 0, 0, 0, 0, 0, 0, 0);
    run_op(0, 1, 0, 2'd2, 32'h204, 32'h5, 1, 5'd6, 32'h0, 2'd3, 0, 0, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_op(kind == 1, kind == 2, 1'($urandom), 2'($urandom), $urandom, $urandom,
             1'($urandom), 5'($urandom), $urandom, 2'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
